// File: rtl/nn_input_buffer_if.sv
// nn_input_buffer_if
// Bundles the push side (from the AHB subordinate), the pop side (array
// controller) and the status outputs of nn_input_buffer.
//   master : drives wr_en_push/is_weight/write_data, weight_pop/input_pop,
//            clear; observes heads, counts, flags and err_flags.
//   slave  : the buffer itself (mirror of master).
interface nn_input_buffer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             wr_en_push;
  logic             is_weight;
  logic [WIDTH-1:0] write_data;
  logic             weight_pop;
  logic             input_pop;
  logic             clear;
  logic [WIDTH-1:0] weight_data;
  logic [WIDTH-1:0] input_data;
  logic [CW-1:0]    weight_count;
  logic [CW-1:0]    input_count;
  logic             weight_empty;
  logic             weight_full;
  logic             input_empty;
  logic             input_full;
  logic             weights_loaded;
  logic [3:0]       err_flags;

  modport master (
    output wr_en_push, is_weight, write_data, weight_pop, input_pop, clear,
    input  weight_data, input_data, weight_count, input_count,
           weight_empty, weight_full, input_empty, input_full,
           weights_loaded, err_flags
  );

  modport slave (
    input  wr_en_push, is_weight, write_data, weight_pop, input_pop, clear,
    output weight_data, input_data, weight_count, input_count,
           weight_empty, weight_full, input_empty, input_full,
           weights_loaded, err_flags
  );
endinterface

// File: rtl/nn_input_buffer.sv
// nn_input_buffer
// Dual show-ahead FIFO staging buffer. Each pushed beat is routed to the
// weight FIFO (is_weight=1) or the input-activation FIFO (is_weight=0).
// Both heads are presented combinationally (0 when empty), with occupancy
// counts, empty/full flags, weights_loaded and sticky error flags
// err_flags = {input underflow, weight underflow, input overflow, weight overflow}.
// Ports:
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset
//   bus    : nn_input_buffer_if.slave (push, pop, clear, status outputs)
module nn_input_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              n_rst,
  nn_input_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  // Per-FIFO results; index 0 = weight FIFO, 1 = input FIFO.
  logic [WIDTH-1:0] head      [2];
  logic [CW-1:0]    count     [2];
  logic             empty     [2];
  logic             full      [2];
  logic             overflow  [2];
  logic             underflow [2];
  logic [3:0]       err_flags_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push_req;
      logic             pop_req;
      logic             push_ok;
      logic             pop_ok;

      assign push_req = bus.wr_en_push & ((gi == 0) ? bus.is_weight : ~bus.is_weight);
      assign pop_req  = (gi == 0) ? bus.weight_pop : bus.input_pop;

      assign empty[gi] = (count_reg == '0);
      assign full[gi]  = (count_reg == CW'(DEPTH));

      // A full FIFO rejects a push even when it is popped in the same cycle;
      // clear swallows both requests without flagging an error.
      assign push_ok = push_req & ~full[gi]  & ~bus.clear;
      assign pop_ok  = pop_req  & ~empty[gi] & ~bus.clear;
      assign overflow[gi]  = push_req & full[gi]  & ~bus.clear;
      assign underflow[gi] = pop_req  & empty[gi] & ~bus.clear;

      // Storage is not reset; stale entries are masked by the empty check.
      always_ff @(posedge clk) begin
        if (push_ok) begin
          mem[wr_ptr_reg] <= bus.write_data;
        end
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (bus.clear) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          // DEPTH is a power of two, so pointer overflow is the wrap.
          if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign count[gi] = count_reg;
      assign head[gi]  = empty[gi] ? '0 : mem[rd_ptr_reg];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_flags_reg <= '0;
    end else if (bus.clear) begin
      err_flags_reg <= '0;
    end else begin
      err_flags_reg <= err_flags_reg | {underflow[1], underflow[0], overflow[1], overflow[0]};
    end
  end

  assign bus.weight_data    = head[0];
  assign bus.input_data     = head[1];
  assign bus.weight_count   = count[0];
  assign bus.input_count    = count[1];
  assign bus.weight_empty   = empty[0];
  assign bus.weight_full    = full[0];
  assign bus.input_empty    = empty[1];
  assign bus.input_full     = full[1];
  assign bus.weights_loaded = full[0];
  assign bus.err_flags      = err_flags_reg;
endmodule

// File: tb/tb_nn_input_buffer.sv
module tb_nn_input_buffer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  nn_input_buffer_if #(.DEPTH(8), .WIDTH(64)) bus ();

  nn_input_buffer #(.DEPTH(8), .WIDTH(64)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests; returns 1 time unit after the sampling edge.
  task automatic step(input logic push, input logic isw, input logic [63:0] d,
                      input logic wp, input logic ip, input logic clr);
    bus.wr_en_push = push;
    bus.is_weight  = isw;
    bus.write_data = d;
    bus.weight_pop = wp;
    bus.input_pop  = ip;
    bus.clear      = clr;
    @(posedge clk);
    #1;
    bus.wr_en_push = 1'b0;
    bus.is_weight  = 1'b0;
    bus.write_data = '0;
    bus.weight_pop = 1'b0;
    bus.input_pop  = 1'b0;
    bus.clear      = 1'b0;
    $display("step push=%0b isw=%0b d=%0h wp=%0b ip=%0b clr=%0b -> wc=%0d ic=%0d err=%b",
             push, isw, d, wp, ip, clr, bus.weight_count, bus.input_count, bus.err_flags);
  endtask

  initial begin
    bus.wr_en_push = 1'b0;
    bus.is_weight  = 1'b0;
    bus.write_data = '0;
    bus.weight_pop = 1'b0;
    bus.input_pop  = 1'b0;
    bus.clear      = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wcount", bus.weight_count, 0);
    chk("rst_icount", bus.input_count, 0);
    chk("rst_wempty", bus.weight_empty, 1);
    chk("rst_iempty", bus.input_empty, 1);
    chk("rst_wfull", bus.weight_full, 0);
    chk("rst_ifull", bus.input_full, 0);
    chk("rst_loaded", bus.weights_loaded, 0);
    chk("rst_wdata", bus.weight_data, 0);
    chk("rst_idata", bus.input_data, 0);
    chk("rst_err", bus.err_flags, 4'b0000);

    // Fill weight FIFO with 0x11..0x88
    step(1, 1, 64'h11, 0, 0, 0);
    chk("push1_wdata", bus.weight_data, 64'h11);
    chk("push1_wcount", bus.weight_count, 1);
    chk("push1_wempty", bus.weight_empty, 0);
    for (int k = 2; k <= 8; k++) step(1, 1, 64'(k * 'h11), 0, 0, 0);
    chk("fill_wcount", bus.weight_count, 8);
    chk("fill_wfull", bus.weight_full, 1);
    chk("fill_loaded", bus.weights_loaded, 1);
    chk("fill_iempty", bus.input_empty, 1);
    chk("fill_icount", bus.input_count, 0);

    // Drain in order
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_head%0d", k), bus.weight_data, 64'(k * 'h11));
      step(0, 0, 0, 1, 0, 0);
      if (k == 1) chk("drain1_loaded", bus.weights_loaded, 0);
    end
    chk("drain_wempty", bus.weight_empty, 1);
    chk("drain_wdata", bus.weight_data, 0);
    chk("drain_err", bus.err_flags, 4'b0000);

    // Refill, then ninth push with simultaneous pop
    for (int k = 1; k <= 8; k++) step(1, 1, 64'(k * 'h11), 0, 0, 0);
    chk("ovf_head_before", bus.weight_data, 64'h11);
    step(1, 1, 64'hFF, 1, 0, 0);
    chk("ovf_wcount", bus.weight_count, 7);
    chk("ovf_err", bus.err_flags, 4'b0001);
    chk("ovf_head_after", bus.weight_data, 64'h22);
    chk("ovf_loaded", bus.weights_loaded, 0);

    // Clear, underflow on input, then clear with push
    step(0, 0, 0, 0, 0, 1);
    chk("clr_err", bus.err_flags, 4'b0000);
    chk("clr_wcount", bus.weight_count, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("udf_err", bus.err_flags, 4'b1000);
    chk("udf_icount", bus.input_count, 0);
    step(1, 1, 64'h77, 0, 1, 1);
    chk("clrpush_err", bus.err_flags, 4'b0000);
    chk("clrpush_wcount", bus.weight_count, 0);
    chk("clrpush_icount", bus.input_count, 0);

    // Wrap-around of the input FIFO with interleaved weight pushes
    for (int k = 0; k < 6; k++) step(1, 0, 64'h30 + 64'(k), 0, 0, 0);
    chk("wrap_icount6", bus.input_count, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wrap_pre%0d", k), bus.input_data, 64'h30 + 64'(k));
      step(0, 0, 0, 0, 1, 0);
    end
    chk("wrap_iempty", bus.input_empty, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 64'hA0 + 64'(k), 0, 0, 0);
      if (k < 3) step(1, 1, 64'h50 + 64'(k), 0, 0, 0);
    end
    chk("wrap_icount5", bus.input_count, 5);
    chk("wrap_wcount3", bus.weight_count, 3);
    chk("wrap_whead", bus.weight_data, 64'h50);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap_head%0d", k), bus.input_data, 64'hA0 + 64'(k));
      step(0, 0, 0, 0, 1, 0);
      chk($sformatf("wrap_wcnt%0d", k), bus.weight_count, 3);
    end
    chk("wrap_done_iempty", bus.input_empty, 1);
    chk("wrap_err", bus.err_flags, 4'b0000);

    // Simultaneous push+pop on an input FIFO holding 3 entries
    step(0, 0, 0, 0, 0, 1);
    q.delete();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 64'hC0 + 64'(k), 0, 0, 0);
      q.push_back(64'hC0 + 64'(k));
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pp_head%0d", k), bus.input_data, q[0]);
      step(1, 0, 64'hD0 + 64'(k), 0, 1, 0);
      void'(q.pop_front());
      q.push_back(64'hD0 + 64'(k));
      chk($sformatf("pp_count%0d", k), bus.input_count, 3);
    end
    chk("pp_final_head", bus.input_data, q[0]);

    // Asynchronous reset mid-burst
    step(1, 1, 64'hE1, 0, 0, 0);
    step(1, 1, 64'hE2, 0, 0, 0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_wcount", bus.weight_count, 0);
    chk("arst_icount", bus.input_count, 0);
    chk("arst_wdata", bus.weight_data, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 64'hDD, 0, 0, 0);
    chk("arst_first_head", bus.weight_data, 64'hDD);
    chk("arst_first_count", bus.weight_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
